// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
//
// Shared constants and helpers for the pipelined carry-lookahead adder.
//
//   GRP_W       width of one lookahead group (one pipeline stage per group)
//   grp_t       one group's worth of operand or sum bits
//   cla_stages  number of groups / pipeline stages for a given word width
// ---------------------------------------------------------------------------
package cla_pkg;

    localparam int GRP_W = 4;

    typedef logic [GRP_W-1:0] grp_t;

    // The word is split into equal groups, so the width is expected to be a
    // whole multiple of the group width.
    function automatic int cla_stages(input int width);
        return width / GRP_W;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// ---------------------------------------------------------------------------
// cla_group4
//
// Purely combinational 4-bit carry-lookahead group. Every internal carry is
// expanded from the bit generate/propagate terms and the group carry in, so
// there is no ripple path inside the group.
//
// Ports
//   a, b   group operand bits (b already inverted by the caller for subtract)
//   ci     carry into bit 0 of the group
//   s      group sum bits
//   co     carry out of bit 3 of the group
//   p      group propagate (all four bits propagate)
//   g      group generate (the group produces a carry on its own)
// ---------------------------------------------------------------------------
module cla_group4
    import cla_pkg::*;
(
    input  logic [GRP_W-1:0] a,
    input  logic [GRP_W-1:0] b,
    input  logic             ci,
    output logic [GRP_W-1:0] s,
    output logic             co,
    output logic             p,
    output logic             g
);

    logic [GRP_W-1:0] pb;
    logic [GRP_W-1:0] gb;
    logic             c1;
    logic             c2;
    logic             c3;

    assign pb = a ^ b;
    assign gb = a & b;

    // Each carry is a flat sum of products over the lower bits and ci.
    assign c1 = gb[0]
              | (pb[0] & ci);
    assign c2 = gb[1]
              | (pb[1] & gb[0])
              | (pb[1] & pb[0] & ci);
    assign c3 = gb[2]
              | (pb[2] & gb[1])
              | (pb[2] & pb[1] & gb[0])
              | (pb[2] & pb[1] & pb[0] & ci);

    assign p = &pb;
    assign g = gb[3]
             | (pb[3] & gb[2])
             | (pb[3] & pb[2] & gb[1])
             | (pb[3] & pb[2] & pb[1] & gb[0]);

    // c4 expressed through the group terms: G + P.ci
    assign co = g | (p & ci);

    assign s = pb ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// cla_pipe_adder
//
// Pipelined adder/subtractor built from 4-bit lookahead groups. The operands
// are captured into an input stage (with B inverted and carry forced to 1 for
// subtract), then one group is resolved per stage, the carry between groups
// travelling in a register. Untouched operand bits and already produced sum
// bits ride along in skew registers so every beat stays coherent. A beat
// accepted on edge t is presented after edge t+STAGES.
//
// Flow control is a single advance signal: the whole pipe moves when the
// output register is empty or being drained, and freezes otherwise.
//
// Parameters
//   WIDTH      operand/sum width, multiple of 4, at least 4
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat offered
//   in_ready   beat accepted this cycle
//   a, b       operands
//   cin        carry in (add mode only)
//   sub        1: a - b, 0: a + b + cin
//   out_valid  result presented
//   out_ready  consumer takes the result this cycle
//   sum        result
//   cout       carry out of the MSB (1 = no borrow in subtract mode)
//   ovf        signed overflow, only when CLA_PIPE_OVF_EN is defined
//
// Build option
//   CLA_PIPE_OVF_EN  adds the ovf port and its pipeline register
// ---------------------------------------------------------------------------
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STAGES = cla_stages(WIDTH);

    // Register level 0 holds the captured beat; level k+1 holds the beat
    // after group k has been resolved. Level STAGES drives the outputs.
    logic             vld   [0:STAGES];
    logic             carry [0:STAGES];
    logic [WIDTH-1:0] op_a  [0:STAGES-1];
    logic [WIDTH-1:0] op_b  [0:STAGES-1];
    logic [WIDTH-1:0] res   [1:STAGES];

    logic [WIDTH-1:0] res_nxt [0:STAGES-1];
    grp_t             grp_s   [0:STAGES-1];
    logic             grp_co  [0:STAGES-1];
    logic             grp_p   [0:STAGES-1];
    logic             grp_g   [0:STAGES-1];

    logic             adv;
    logic             word_co;

    assign out_valid = vld[STAGES];
    assign sum       = res[STAGES];
    assign cout      = carry[STAGES];

    // The whole pipe moves together; nothing moves while the output holds a
    // result the consumer has not taken.
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    // Final carry out built straight from the last group's G/P terms.
    assign word_co = grp_g[STAGES-1] | (grp_p[STAGES-1] & carry[STAGES-1]);

    // One lookahead group per stage; each stage merges its nibble into the
    // partial sum it received from the stage before.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] base;

        if (k == 0) begin : g_first
            assign base = '0;
        end else begin : g_rest
            assign base = res[k];
        end

        cla_group4 u_grp (
            .a  (op_a[k][GRP_W*k +: GRP_W]),
            .b  (op_b[k][GRP_W*k +: GRP_W]),
            .ci (carry[k]),
            .s  (grp_s[k]),
            .co (grp_co[k]),
            .p  (grp_p[k]),
            .g  (grp_g[k])
        );

        assign res_nxt[k] = (base & ~({{(WIDTH-GRP_W){1'b0}}, {GRP_W{1'b1}}} << (GRP_W*k)))
                          | ({{(WIDTH-GRP_W){1'b0}}, grp_s[k]} << (GRP_W*k));
    end

    // Pipeline registers. Subtract is folded in at capture time so the
    // stages only ever add. Bubbles travel as cleared valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= STAGES; k++) begin
                vld[k]   <= 1'b0;
                carry[k] <= 1'b0;
            end
            for (int k = 0; k < STAGES; k++) begin
                op_a[k] <= '0;
                op_b[k] <= '0;
            end
            for (int k = 1; k <= STAGES; k++) begin
                res[k] <= '0;
            end
        end else if (adv) begin
            vld[0]   <= in_valid;
            op_a[0]  <= a;
            op_b[0]  <= sub ? ~b : b;
            carry[0] <= sub | cin;

            for (int k = 1; k < STAGES; k++) begin
                op_a[k] <= op_a[k-1];
                op_b[k] <= op_b[k-1];
            end

            for (int k = 0; k < STAGES; k++) begin
                vld[k+1] <= vld[k];
                res[k+1] <= res_nxt[k];
            end

            for (int k = 0; k < STAGES - 1; k++) begin
                carry[k+1] <= grp_co[k];
            end
            carry[STAGES] <= word_co;
        end
    end

`ifdef CLA_PIPE_OVF_EN
    logic msb_ci;

    // Carry into the MSB recovered from the MSB operand and sum bits.
    assign msb_ci = op_a[STAGES-1][WIDTH-1]
                  ^ op_b[STAGES-1][WIDTH-1]
                  ^ grp_s[STAGES-1][GRP_W-1];

    // Overflow travels with the final stage so it lines up with sum/cout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (adv) begin
            ovf <= msb_ci ^ word_co;
        end
    end
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_pipe_adder
//
// Self-checking bench for cla_pipe_adder at WIDTH=16 (four stages): reset
// values, exact latency of single beats on hand-computed vectors, a stalled
// back-to-back burst, reset with beats in flight, and a random stream
// against a reference adder. Define CLA_PIPE_OVF_EN to also check ovf.
// ---------------------------------------------------------------------------
module tb_cla_pipe_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;
    localparam int NRAND  = 2000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_PIPE_OVF_EN
    logic             ovf;
`endif

    int testCount = 0;
    int failCount = 0;

    logic [17:0] expQ [$];

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Offers one operand beat; the caller decides when to drop in_valid.
    task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic cv, input logic sv);
        a        = av;
        b        = bv;
        cin      = cv;
        sub      = sv;
        in_valid = 1'b1;
    endtask

    // Reference: {ovf, cout, sum} of a + effB + effCin.
    function automatic logic [17:0] refModel(input logic [15:0] av, input logic [15:0] bv, input logic cv, input logic sv);
        logic [15:0] eb;
        logic        ec;
        logic [16:0] r;
        logic        o;
        eb = sv ? ~bv : bv;
        ec = sv ? 1'b1 : cv;
        r  = {1'b0, av} + {1'b0, eb} + {16'b0, ec};
        o  = (av[15] == eb[15]) && (r[15] != av[15]);
        return {o, r};
    endfunction

    // One isolated beat: accepted on the next edge t, must stay invisible
    // through edge t+STAGES-1 and appear right after edge t+STAGES.
    task automatic runSingle(input string tag, input logic [15:0] av, input logic [15:0] bv,
                             input logic cv, input logic sv, input logic [15:0] expSum,
                             input logic expCout, input logic expOvf);
        out_ready = 1'b1;
        applyStimulus(av, bv, cv, sv);
        @(negedge clk);
        checkOutput({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        checkOutput({tag, "_early_t0"}, out_valid, 0);
        for (int i = 1; i < STAGES; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("%s_early_t%0d", tag, i), out_valid, 0);
        end
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid"}, out_valid, 1);
        checkOutput({tag, "_sum"}, sum, expSum);
        checkOutput({tag, "_cout"}, cout, expCout);
`ifdef CLA_PIPE_OVF_EN
        checkOutput({tag, "_ovf"}, ovf, expOvf);
`else
        if (expOvf === 1'bx) $display("[TB] note: %s ovf unknown", tag);
`endif
        @(posedge clk);
        #1;
        checkOutput({tag, "_drained"}, out_valid, 0);
        #1;
    endtask

    // Back-to-back burst, hand-computed results {cout, sum}.
    logic [15:0] bpA   [8] = '{16'h0001, 16'h00FF, 16'h0FFF, 16'hFFFF, 16'h0010, 16'h0001, 16'h1234, 16'h8000};
    logic [15:0] bpB   [8] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0002, 16'h4321, 16'h8000};
    logic        bpC   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        bpS   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [16:0] bpExp [8] = '{17'h00002, 17'h00100, 17'h01000, 17'h10000,
                               17'h1000F, 17'h0FFFF, 17'h05556, 17'h10000};

    initial begin
        int          idx;
        int          rcount;
        int          sent;
        int          got;
        logic        accepted;
        logic [17:0] expV;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;

        // Reset values
        #3;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_sum", sum, 0);
        checkOutput("rst_cout", cout, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Directed single beats
        runSingle("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        runSingle("add_ffff_cin",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        runSingle("add_ffff_1",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        runSingle("add_0fff_cin",  16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
        runSingle("add_7fff_1",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        runSingle("add_8000_8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        runSingle("sub_5_7",       16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        runSingle("sub_abcd_abcd", 16'hABCD, 16'hABCD, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        runSingle("sub_0_1",       16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);

        // Back-to-back burst, consumer stalls in cycles 6..8
        idx    = 0;
        rcount = 0;
        for (int c = 0; c < 40 && rcount < 8; c++) begin
            out_ready = !(c >= 6 && c <= 8);
            if (idx < 8) begin
                applyStimulus(bpA[idx], bpB[idx], bpC[idx], bpS[idx]);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c <= 12) begin
                checkOutput($sformatf("bp_in_ready_c%0d", c), in_ready, (c >= 6 && c <= 8) ? 0 : 1);
            end
            if (out_valid && !out_ready && rcount < 8) begin
                checkOutput($sformatf("bp_hold_c%0d", c), {15'b0, cout, sum}, {15'b0, bpExp[rcount]});
            end
            if (out_valid && out_ready) begin
                if (rcount < 8) begin
                    checkOutput($sformatf("bp_result%0d", rcount), {15'b0, cout, sum}, {15'b0, bpExp[rcount]});
                end else begin
                    checkOutput("bp_extra_result", out_valid, 0);
                end
                rcount++;
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        checkOutput("bp_result_count", rcount, 8);
        checkOutput("bp_beats_taken", idx, 8);

        // Reset with three beats in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'h1111 * (i + 1), 16'h0001, 1'b0, 1'b0);
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_sum", sum, 0);
        checkOutput("midrst_cout", cout, 0);
        checkOutput("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        checkOutput("midrst_held_valid", out_valid, 0);
        #1;
        rst_n = 1'b1;
        runSingle("post_rst", 16'h2222, 16'h1111, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);

        // Random stream with random backpressure
        sent     = 0;
        got      = 0;
        accepted = 1'b1;
        in_valid = 1'b0;
        for (int c = 0; c < 20000 && got < NRAND; c++) begin
            if (!in_valid || accepted) begin
                in_valid = (sent < NRAND) && ($urandom_range(0, 3) != 0);
                a        = 16'($urandom);
                b        = 16'($urandom);
                cin      = 1'($urandom);
                sub      = 1'($urandom);
            end
            out_ready = (sent >= NRAND) || ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("rand_spurious_out", out_valid, 0);
                end else begin
                    expV = expQ.pop_front();
                    checkOutput($sformatf("rand_result%0d", got), {15'b0, cout, sum}, {15'b0, expV[16:0]});
`ifdef CLA_PIPE_OVF_EN
                    checkOutput($sformatf("rand_ovf%0d", got), ovf, expV[17]);
`endif
                end
                got++;
            end
            accepted = in_valid && in_ready;
            if (accepted) begin
                expQ.push_back(refModel(a, b, cin, sub));
                sent++;
            end
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        checkOutput("rand_result_count", got, NRAND);
        checkOutput("rand_queue_empty", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
